// File: rtl/core_defines.sv
// Shared register-file writeback definitions: address/data widths and the
// MDU result entry carried through the writeback FIFO.
package core_defines;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for MDU writeback entries. Pointers wrap modulo
// FIFO_DEPTH (power of 2); the extra count bit tells full from empty.
// Push while full and pop while empty are ignored.
module wb_fifo
    import core_defines::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        push_i,
    input  wb_entry_t                   push_data_i,
    input  logic                        pop_i,
    output wb_entry_t                   head_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = PtrW + 1;

    wb_entry_t             mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0]     count_q, count_d;
    logic                  push_en, pop_en;

    assign full_o  = (count_q == CountW'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    // Next pointer and occupancy from this cycle's push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_en && !pop_en) begin
            count_d = count_q + 1'b1;
        end else if (!push_en && pop_en) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless while not counted.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the non-stallable pipeline result and buffered
// MDU results into one registered register-file write per cycle, with a
// starvation guard for the FIFO and a pending-register scoreboard.
// Optional sticky protocol-error flag enabled by defining WB_ERRCHK_EN.
module wb_arbiter
    import core_defines::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pipe_valid,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]       pipe_data,
    output logic                  pipe_stall,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [REG_ADDR_W-1:0] mdu_rd,
    input  logic [XLEN-1:0]       mdu_data,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
`ifdef WB_ERRCHK_EN
    output logic                  err,
`endif
    output logic                  wEn,
    output logic [REG_ADDR_W-1:0] write_sel,
    output logic [XLEN-1:0]       write_data
);

    localparam int unsigned StarveW = $clog2(STARVE_MAX);

    wb_entry_t                   head, push_entry;
    logic                        fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        pipe_wr;

    logic                        wen_q, wen_d;
    logic [REG_ADDR_W-1:0]       sel_q, sel_d;
    logic [XLEN-1:0]             data_q, data_d;
    logic                        stall_q, stall_d;
    logic [StarveW-1:0]          starve_q, starve_d;
    logic [NUM_REGS-1:0]         pend_q, pend_d;

    assign push_entry = '{rd: mdu_rd, data: mdu_data};
    assign mdu_ready  = !fifo_full;
    assign fifo_push  = mdu_valid && mdu_ready;
    // A result offered during stall is dropped; rd=0 never claims the slot.
    assign pipe_wr    = pipe_valid && !stall_q && (pipe_rd != '0);
    assign fifo_pop   = !fifo_empty && (stall_q || !pipe_wr);

    assign pipe_stall = stall_q;
    assign wEn        = wen_q;
    assign write_sel  = sel_q;
    assign write_data = data_q;
    assign rs1_busy   = pend_q[rs1];
    assign rs2_busy   = pend_q[rs2];

    wb_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clock),
        .rst_ni      (reset),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    a_fifo_consistent: assert property (@(posedge clock) disable iff (!reset)
        fifo_empty == (fifo_count == '0));

    // Slot selection: forced drain, then pipeline, then opportunistic drain.
    always_comb begin
        wen_d  = 1'b0;
        sel_d  = sel_q;
        data_d = data_q;
        if (fifo_pop) begin
            if (head.rd != '0) begin
                wen_d  = 1'b1;
                sel_d  = head.rd;
                data_d = head.data;
            end
        end else if (pipe_wr) begin
            wen_d  = 1'b1;
            sel_d  = pipe_rd;
            data_d = pipe_data;
        end
    end

    // Starvation: count cycles the FIFO loses the slot; on reaching
    // STARVE_MAX-1 raise a one-cycle stall and restart the count.
    always_comb begin
        starve_d = '0;
        stall_d  = 1'b0;
        if (!fifo_empty && !fifo_pop) begin
            if (starve_q == StarveW'(STARVE_MAX - 2)) begin
                stall_d = 1'b1;
            end else begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    // Scoreboard: clear on FIFO drain, then set on issue so set wins.
    always_comb begin
        pend_d = pend_q;
        if (fifo_pop && (head.rd != '0)) pend_d[head.rd] = 1'b0;
        if (iss_valid && (iss_rd != '0)) pend_d[iss_rd] = 1'b1;
        pend_d[0] = 1'b0;
    end

    // Registered write port, stall pulse, starve counter and scoreboard.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wen_q    <= 1'b0;
            sel_q    <= '0;
            data_q   <= '0;
            stall_q  <= 1'b0;
            starve_q <= '0;
            pend_q   <= '0;
        end else begin
            wen_q    <= wen_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            stall_q  <= stall_d;
            starve_q <= starve_d;
            pend_q   <= pend_d;
        end
    end

`ifdef WB_ERRCHK_EN
    logic err_q, err_d;

    assign err = err_q;

    // Sticky protocol-violation flag.
    always_comb begin
        err_d = err_q;
        if (pipe_valid && stall_q) err_d = 1'b1;
        if (iss_valid && (iss_rd != '0) && pend_q[iss_rd]) err_d = 1'b1;
        if (fifo_push && (mdu_rd != '0) && !pend_q[mdu_rd]) err_d = 1'b1;
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue/array reference model, a
// negedge compare process, directed scenarios with literal expectations and
// a randomized phase.
module tb_wb_arbiter;
    import core_defines::*;

    localparam int FIFO_DEPTH = 4;
    localparam int STARVE_MAX = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pipe_valid, mdu_valid, iss_valid;
    logic [4:0]  pipe_rd, mdu_rd, iss_rd, rs1, rs2;
    logic [31:0] pipe_data, mdu_data;
    logic        pipe_stall, mdu_ready, rs1_busy, rs2_busy, wEn;
    logic [4:0]  write_sel;
    logic [31:0] write_data;
`ifdef WB_ERRCHK_EN
    logic        err;
`endif

    wb_arbiter #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pipe_valid (pipe_valid),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .pipe_stall (pipe_stall),
        .mdu_valid  (mdu_valid),
        .mdu_ready  (mdu_ready),
        .mdu_rd     (mdu_rd),
        .mdu_data   (mdu_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
`ifdef WB_ERRCHK_EN
        .err        (err),
`endif
        .wEn        (wEn),
        .write_sel  (write_sel),
        .write_data (write_data)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, pending set as a bit array, and a
    // run length of consecutive cycles the queue lost the slot.
    wb_entry_t   m_q[$];
    bit          m_pend[32];
    bit          m_wen;
    logic [4:0]  m_sel;
    logic [31:0] m_data;
    bit          m_stall;
    int          m_blocked;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_pend    = '{default: 1'b0};
            m_wen     = 1'b0;
            m_sel     = '0;
            m_data    = '0;
            m_stall   = 1'b0;
            m_blocked = 0;
        end else begin
            bit        nonempty, can_push, pipe_wins, took_head;
            wb_entry_t e;
            nonempty  = (m_q.size() != 0);
            can_push  = mdu_valid && (m_q.size() < FIFO_DEPTH);
            pipe_wins = pipe_valid && (pipe_rd != 0) && !m_stall;
            took_head = nonempty && (m_stall || !pipe_wins);
            m_wen = 1'b0;
            if (took_head) begin
                e = m_q.pop_front();
                if (e.rd != 0) begin
                    m_wen      = 1'b1;
                    m_sel      = e.rd;
                    m_data     = e.data;
                    m_pend[e.rd] = 1'b0;
                end
            end else if (pipe_wins) begin
                m_wen  = 1'b1;
                m_sel  = pipe_rd;
                m_data = pipe_data;
            end
            if (nonempty && !took_head) m_blocked++;
            else                        m_blocked = 0;
            m_stall = 1'b0;
            if (m_blocked == STARVE_MAX - 1) begin
                m_stall   = 1'b1;
                m_blocked = 0;
            end
            if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
            if (can_push) m_q.push_back('{rd: mdu_rd, data: mdu_data});
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clock) begin
        if (chk_en) begin
            check("wEn", wEn, m_wen);
            check("write_sel", write_sel, m_sel);
            check("write_data", write_data, m_data);
            check("pipe_stall", pipe_stall, m_stall);
            check("mdu_ready", mdu_ready, m_q.size() < FIFO_DEPTH);
            check("rs1_busy", rs1_busy, m_pend[rs1]);
            check("rs2_busy", rs2_busy, m_pend[rs2]);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
        mdu_valid  = 1'b0; mdu_rd  = '0; mdu_data  = '0;
        iss_valid  = 1'b0; iss_rd  = '0;
    endtask

    task automatic mdu_beat(input logic [4:0] rd, input logic [31:0] d);
        mdu_valid = 1'b1; mdu_rd = rd; mdu_data = d;
    endtask

    initial begin
        idle();
        rs1 = '0; rs2 = '0;
        #2 reset = 1'b0;
        chk_en = 1'b1;
        #1;
        check("reset_wEn", wEn, 1'b0);
        check("reset_mdu_ready", mdu_ready, 1'b1);
        repeat (2) step();
        reset = 1'b1;
        step();

        // Pipeline pass-through, one cycle latency.
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEAD_BEEF;
        step();
        idle();
        check("pass_wEn", wEn, 1'b1);
        check("pass_sel", write_sel, 5'd5);
        check("pass_data", write_data, 32'hDEAD_BEEF);
        step();

        // MDU drain on an idle slot, with scoreboard clear.
        iss_valid = 1'b1; iss_rd = 5'd7; rs1 = 5'd7;
        step();
        iss_valid = 1'b0;
        check("drain_busy_before", rs1_busy, 1'b1);
        mdu_beat(5'd7, 32'h12);
        step();
        idle();
        check("drain_no_bypass", wEn, 1'b0);
        check("drain_busy_held", rs1_busy, 1'b1);
        step();
        check("drain_wEn", wEn, 1'b1);
        check("drain_sel", write_sel, 5'd7);
        check("drain_data", write_data, 32'h12);
        check("drain_busy_after", rs1_busy, 1'b0);

        // Fill the FIFO under a busy pipeline until the starvation stall.
        for (int c = 0; c < 8; c++) begin
            pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h100 + c;
            if (c < 4) mdu_beat(5'(10 + c), 32'(200 + c));
            else       mdu_valid = 1'b0;
            step();
            if (c == 3) check("full_ready", mdu_ready, 1'b0);
            if (c < 7)  check("no_stall_yet", pipe_stall, 1'b0);
        end
        check("stall_pulse", pipe_stall, 1'b1);
        idle();
        step();
        check("stall_wEn", wEn, 1'b1);
        check("stall_sel", write_sel, 5'd10);
        check("stall_data", write_data, 32'd200);
        check("stall_ends", pipe_stall, 1'b0);
        check("stall_ready", mdu_ready, 1'b1);
        repeat (4) step();

        // Same-cycle set and clear of pending[9]: set wins.
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        iss_valid = 1'b0;
        mdu_beat(5'd9, 32'h99);
        step();
        mdu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd9; rs1 = 5'd9;
        step();
        iss_valid = 1'b0;
        check("setclr_sel", write_sel, 5'd9);
        check("setclr_busy", rs1_busy, 1'b1);

        // x0: pipe_rd=0 frees the slot; iss rd=0 never pends; rd=0 entry is silent.
        pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_data = 32'h44;
        mdu_beat(5'd3, 32'h33);
        step();
        mdu_valid = 1'b0; pipe_rd = 5'd0;
        check("x0_pipe_sel", write_sel, 5'd4);
        step();
        idle();
        check("x0_fifo_wEn", wEn, 1'b1);
        check("x0_fifo_sel", write_sel, 5'd3);
        check("x0_fifo_data", write_data, 32'h33);
        iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
        step();
        iss_valid = 1'b0;
        check("x0_iss_busy", rs1_busy, 1'b0);
        mdu_beat(5'd0, 32'h55);
        step();
        mdu_valid = 1'b0;
        step();
        check("x0_entry_wEn", wEn, 1'b0);
        check("x0_entry_hold_sel", write_sel, 5'd3);
        check("x0_entry_hold_data", write_data, 32'h33);

        // Reset mid-stream with two FIFO entries and pending bits.
        iss_valid = 1'b1; iss_rd = 5'd20;
        step();
        iss_rd = 5'd21;
        step();
        iss_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            pipe_valid = 1'b1; pipe_rd = 5'd2; pipe_data = 32'hA0 + c;
            mdu_beat(5'(20 + c), 32'(300 + c));
            step();
        end
        mdu_valid = 1'b0;
        rs1 = 5'd20;
        #1;
        check("pre_rst_wEn", wEn, 1'b1);
        check("pre_rst_busy", rs1_busy, 1'b1);
        reset = 1'b0;
        #1;
        check("rst_wEn_now", wEn, 1'b0);
        idle();
        step();
        reset = 1'b1;
        #1;
        check("rst_ready", mdu_ready, 1'b1);
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            #1;
            check("rst_busy_clear", rs1_busy, 1'b0);
        end
        step();

        // Randomized phase; heavy pipeline first to provoke starvation.
        for (int n = 0; n < 4000; n++) begin
            int pv_pct;
            pv_pct     = (n < 2000) ? 88 : 50;
            pipe_valid = ($urandom_range(0, 99) < pv_pct) &&
                         (!pipe_stall || ($urandom_range(0, 15) == 0));
            pipe_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            pipe_data  = $urandom;
            mdu_valid  = ($urandom_range(0, 99) < 40);
            mdu_rd     = 5'($urandom_range(0, 31));
            mdu_data   = $urandom;
            iss_valid  = ($urandom_range(0, 99) < 30);
            iss_rd     = 5'($urandom_range(0, 31));
            rs1        = 5'($urandom_range(0, 31));
            rs2        = 5'($urandom_range(0, 31));
            if (n == 2500) begin
                reset = 1'b0;
                #1;
                check("rand_rst_wEn", wEn, 1'b0);
                step();
                reset = 1'b1;
            end
            step();
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-side driver for the 32x32 register file write port (wEn, write_sel, write_data).
- Merges two producers into one registered write per cycle:
  - the in-order pipeline result, which cannot be back-pressured;
  - the multi-cycle mul/div unit (MDU) result, accepted via valid/ready and buffered in a small FIFO.
- Keeps a pending-register scoreboard that decode queries for stalls.

Parameters:
- FIFO_DEPTH, 4, MDU result FIFO entries (power of 2, >=2).
- STARVE_MAX, 8, consecutive cycles a non-empty FIFO may be blocked by the pipeline before a forced drain slot.

Ports:
- clock  in  1  system clock, posedge.
- reset  in  1  asynchronous, active-low reset.
- pipe_valid  in  1  pipeline result present this cycle.
- pipe_rd  in  5  pipeline destination register.
- pipe_data  in  32  pipeline result.
- pipe_stall  out  1  registered; upstream must hold pipe_valid=0 while high.
- mdu_valid  in  1  MDU result offered.
- mdu_ready  out  1  FIFO not full (combinational).
- mdu_rd  in  5  MDU destination register.
- mdu_data  in  32  MDU result.
- iss_valid  in  1  long-latency op issued this cycle.
- iss_rd  in  5  its destination, marked pending.
- rs1  in  5  decode source 1 query.
- rs2  in  5  decode source 2 query.
- rs1_busy  out  1  pending[rs1] (combinational).
- rs2_busy  out  1  pending[rs2] (combinational).
- wEn  out  1  register file write enable (registered).
- write_sel  out  5  register file write index (registered).
- write_data  out  32  register file write data (registered).

Behaviour:
- Reset (reset=0, asynchronous): wEn=0, write_sel=0, write_data=0, pipe_stall=0, FIFO empty, starve counter=0, all pending bits=0. No writes while in reset.
- Handshake: an MDU beat is accepted when mdu_valid && mdu_ready. It is pushed at the posedge. A full FIFO deasserts mdu_ready, and the MDU holds its beat.
- Per-cycle slot selection, latched at the posedge; the register file commits it on the following negedge:
  1. pipe_stall=1 and FIFO non-empty: pop head. Sets wEn=1, write_sel=head.rd, write_data=head.data.
  2. Otherwise, pipe_valid && pipe_rd!=0: write the pipeline result.
  3. Otherwise, FIFO non-empty: pop head as in 1.
  4. Otherwise: wEn=0; write_sel and write_data hold their previous values.
- pipe_valid with pipe_rd=0 counts as no write and frees the slot for the FIFO.
- Latency: pipeline result reaches wEn one cycle after pipe_valid. An MDU beat accepted into an empty FIFO with the slot free is written out the next cycle (no bypass; push then pop next cycle).
- FIFO entries with rd=0 are popped and emitted with wEn=0.
- FIFO supports simultaneous push and pop when full: the pop frees a slot, but mdu_ready is computed from pre-pop state, so a full FIFO accepts no push that cycle.
- Pointers wrap modulo FIFO_DEPTH. A count of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.
- Starvation:
  - The counter increments each cycle in which the FIFO is non-empty and the slot went to the pipeline.
  - It clears on any FIFO pop or when the FIFO is empty.
  - When the counter reaches STARVE_MAX-1, pipe_stall is asserted for exactly the next cycle and the counter clears.
- Scoreboard:
  - iss_valid && iss_rd!=0 sets pending[iss_rd].
  - A FIFO pop with rd!=0 clears pending[rd].
  - Set and clear of the same index in the same cycle: set wins.
  - Pipeline writes never touch pending bits.
  - pending[0] is constant 0.
- Reset mid-operation discards FIFO contents and pending bits, with no partial write emitted.

Optional Feature:
- Macro: WB_ERRCHK_EN.
- When defined, adds output port err (1 bit). It is a sticky flag, cleared only by reset, and set the cycle after any of:
  - pipe_valid=1 while pipe_stall=1;
  - iss_valid with iss_rd already pending;
  - an accepted MDU beat with rd!=0 whose pending bit is 0.
- When not defined, the port and logic are absent; violating inputs behave as the rules above (pipe_valid during stall is dropped).

Decomposition:
- Shared package (core_defines): REG_ADDR_W=5, XLEN=32, NUM_REGS=32, a wb_entry struct {rd[4:0], data[31:0]}.
- One sub-module: wb_fifo (parameterised synchronous FIFO; push/pop/full/empty/count, async active-low reset). Arbitration, starve counter and scoreboard stay in wb_arbiter.

Test Plan:
- Reset: assert reset=0 mid-stream with 2 FIFO entries -> wEn=0 immediately; after release, rs1_busy=0 for all indices, mdu_ready=1.
- Pipeline pass-through: pipe_valid=1, pipe_rd=5, pipe_data=0xDEADBEEF at cycle N -> wEn=1, write_sel=5, write_data=0xDEADBEEF at N+1.
- MDU drain on idle slot: iss rd=7, then MDU beat rd=7, data=0x12 with pipe idle -> written 1 cycle after acceptance; rs1=7 busy until that posedge, then 0.
- Full FIFO (FIFO_DEPTH=4): 4 MDU beats accepted while pipe writes every cycle -> mdu_ready=0 with 4 entries held. After 7 blocked cycles (counter reaches STARVE_MAX-1=7) -> pipe_stall pulses 1 cycle and the head is written in that stall cycle.
- Simultaneous set/clear: iss rd=9 in the same cycle the FIFO pops an rd=9 entry -> pending[9] stays 1.
- x0 handling: pipe_rd=0 with FIFO non-empty -> FIFO head written that slot. Iss rd=0 -> rs1_busy(rs1=0) stays 0.
